data_memory_arbiter: RTL

Sequences and shares the single-ported word-addressed data memory (1024 x 32) between two requesters: port 0 is the pipeline MEM stage, port 1 is the program/data loader and debug port. It grants one request at a time with round-robin fairness and holds the memory control, address and write-data lines stable for a fixed access window. It then returns read data with a one-cycle done pulse. It sits between the MEM stage and the data memory, and its done signal drives the pipeline stall logic.

---
 rtl/data_memory_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter_2.sv | 24 ++
 rtl/data_memory_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared state encoding, port identifiers and default geometry for the
// data memory arbiter and its round-robin picker.
package data_memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH    = 10;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ACCESS_CYCLES = 2;

  localparam logic PORT_MEM_STAGE = 1'b0;
  localparam logic PORT_LOADER    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick producing a one-hot grant.
module rr_arbiter_2
  import data_memory_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_lastGrant,
  output logic [1:0] o_grant
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    o_grant = 2'b00;
    if (i_valid == 2'b11) begin
      if (i_lastGrant == PORT_LOADER) begin
        o_grant[PORT_MEM_STAGE] = 1'b1;
      end else begin
        o_grant[PORT_LOADER] = 1'b1;
      end
    end else begin
      o_grant = i_valid;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-ported data memory between the MEM stage and the loader
// port: round-robin grant, fixed-length access window, one-cycle done pulse.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0Valid,
  input  logic                  req0Write,
  input  logic [31:0]           req0Address,
  input  logic [DATA_WIDTH-1:0] req0WriteData,
  input  logic                  req1Valid,
  input  logic                  req1Write,
  input  logic [31:0]           req1Address,
  input  logic [DATA_WIDTH-1:0] req1WriteData,
  output logic                  req0Done,
  output logic                  req0Error,
  output logic [DATA_WIDTH-1:0] req0ReadData,
  output logic                  req1Done,
  output logic                  req1Error,
  output logic [DATA_WIDTH-1:0] req1ReadData,
  output logic                  memoryRead,
  output logic                  memoryWrite,
  output logic [31:0]           address,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ACCESS_CYCLES);

  state_t r_state;
  state_t w_nextState;

  logic [CW-1:0]         r_count;
  logic                  r_lastGrant;
  logic                  r_grantPort;
  logic                  r_grantWrite;
  logic                  r_grantError;
  logic [31:0]           r_address;
  logic [DATA_WIDTH-1:0] r_writeData;
  logic [DATA_WIDTH-1:0] r_readData0;
  logic [DATA_WIDTH-1:0] r_readData1;

  logic [1:0]            w_grant;
  logic                  w_anyValid;
  logic                  w_winner;
  logic                  w_winWrite;
  logic [31:0]           w_winAddress;
  logic [DATA_WIDTH-1:0] w_winData;
  logic                  w_outOfRange;
  logic                  w_lastCycle;

  rr_arbiter_2 u_rrArbiter (
    .i_valid     ({req1Valid, req0Valid}),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_grant)
  );

  assign w_anyValid   = |w_grant;
  assign w_winner     = w_grant[PORT_LOADER];
  assign w_winWrite   = w_winner ? req1Write     : req0Write;
  assign w_winAddress = w_winner ? req1Address   : req0Address;
  assign w_winData    = w_winner ? req1WriteData : req0WriteData;
  assign w_outOfRange = |w_winAddress[31:ADDR_WIDTH];
  assign w_lastCycle  = (r_count == LAST_COUNT);

  assign address      = r_address;
  assign writeData    = r_writeData;
  assign req0ReadData = r_readData0;
  assign req1ReadData = r_readData1;

  // Out-of-range requests skip ACCESS entirely so the memory never sees them.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_anyValid) w_nextState = w_outOfRange ? RESP : ACCESS;
      ACCESS:  if (w_lastCycle) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    memoryRead  = 1'b0;
    memoryWrite = 1'b0;
    req0Done    = 1'b0;
    req1Done    = 1'b0;
    req0Error   = 1'b0;
    req1Error   = 1'b0;
    busy        = (r_state != IDLE);
    if (r_state == ACCESS) begin
      memoryRead  = !r_grantWrite;
      // Strobe writes only in the last cycle so each write commits once.
      memoryWrite = r_grantWrite && w_lastCycle;
    end
    if (r_state == RESP) begin
      req0Done  = (r_grantPort == PORT_MEM_STAGE);
      req1Done  = (r_grantPort == PORT_LOADER);
      req0Error = (r_grantPort == PORT_MEM_STAGE) && r_grantError;
      req1Error = (r_grantPort == PORT_LOADER) && r_grantError;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_lastGrant  <= PORT_LOADER;
      r_grantPort  <= PORT_MEM_STAGE;
      r_grantWrite <= 1'b0;
      r_grantError <= 1'b0;
      r_address    <= '0;
      r_writeData  <= '0;
      r_readData0  <= '0;
      r_readData1  <= '0;
    end else begin
      r_state <= w_nextState;
      unique case (r_state)
        IDLE: begin
          if (w_anyValid) begin
            r_grantPort  <= w_winner;
            r_grantWrite <= w_winWrite;
            r_grantError <= w_outOfRange;
            if (w_outOfRange) begin
              if (w_winner == PORT_LOADER) r_readData1 <= '0;
              else                         r_readData0 <= '0;
            end else begin
              r_address   <= w_winAddress;
              r_writeData <= w_winData;
              r_count     <= CW'(1);
            end
          end
        end
        ACCESS: begin
          if (w_lastCycle) begin
            r_count <= '0;
            if (!r_grantWrite) begin
              if (r_grantPort == PORT_LOADER) r_readData1 <= readData;
              else                            r_readData0 <= readData;
            end
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        RESP: begin
          r_lastGrant <= r_grantPort;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
